// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Purpose  : Programs one PWM channel (divisor, period, initial duty, control)
//            and then ramps its duty-cycle register from a start value to an
//            end value at a fixed interval, without CPU involvement.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl #(
    parameter int DC_W  = 16,
    parameter int INT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             ch_sel_i,
    input  logic [DC_W-1:0]  cfg_divisor_i,
    input  logic [DC_W-1:0]  cfg_period_i,
    input  logic [DC_W-1:0]  dc_start_i,
    input  logic [DC_W-1:0]  dc_end_i,
    input  logic [DC_W-1:0]  dc_step_i,
    input  logic [INT_W-1:0] interval_i,
    output logic             we_o,
    output logic             re_o,
    output logic [7:0]       addr_o,
    output logic [31:0]      wdata_o,
    output logic [3:0]       be_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [DC_W-1:0]  dc_cur_o
);

    // Control word: start, output enable, wb clock, internal DC source.
    localparam logic [31:0] c_ctrl_run  = 32'h0000_0014;
    localparam logic [31:0] c_ctrl_stop = 32'h0000_0000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_W_DIV  = 4'd1,
        S_W_PER  = 4'd2,
        S_W_DC0  = 4'd3,
        S_W_CTRL = 4'd4,
        S_WAIT   = 4'd5,
        S_W_DC   = 4'd6,
        S_DONE   = 4'd7,
        S_STOP   = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_ch;
    logic             r_up;
    logic [DC_W-1:0]  r_div;
    logic [DC_W-1:0]  r_per;
    logic [DC_W-1:0]  r_dc_start;
    logic [DC_W-1:0]  r_dc_end;
    logic [DC_W-1:0]  r_step;
    logic [INT_W-1:0] r_interval;
    logic [INT_W-1:0] r_cnt;
    logic [DC_W-1:0]  r_dc_cur;

    logic             w_start;
    logic [DC_W:0]    w_sum;
    logic [DC_W:0]    w_diff;
    logic [DC_W-1:0]  w_next;
    logic [7:0]       w_base;

    assign w_start = (r_state == S_IDLE) && start_i;
    assign w_sum   = {1'b0, r_dc_cur} + {1'b0, r_step};
    assign w_diff  = {1'b0, r_dc_cur} - {1'b0, r_step};
    assign w_base  = r_ch ? 8'd16 : 8'd0;

    // Next duty value: move by one step toward dc_end, clamping on overshoot,
    // carry/borrow, or a zero step.
    always_comb begin
        w_next = r_dc_end;
        if (r_step != '0) begin
            if (r_up) begin
                if (w_sum < {1'b0, r_dc_end})
                    w_next = w_sum[DC_W-1:0];
            end else begin
                if (!w_diff[DC_W] && (w_diff[DC_W-1:0] > r_dc_end))
                    w_next = w_diff[DC_W-1:0];
            end
        end
    end

    // Latch the whole configuration on the accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ch       <= 1'b0;
            r_up       <= 1'b0;
            r_div      <= '0;
            r_per      <= '0;
            r_dc_start <= '0;
            r_dc_end   <= '0;
            r_step     <= '0;
            r_interval <= '0;
        end else if (w_start) begin
            r_ch       <= ch_sel_i;
            r_up       <= (dc_end_i >= dc_start_i);
            r_div      <= cfg_divisor_i;
            r_per      <= cfg_period_i;
            r_dc_start <= dc_start_i;
            r_dc_end   <= dc_end_i;
            r_step     <= dc_step_i;
            r_interval <= (interval_i == '0) ? INT_W'(1) : interval_i;
        end
    end

    // Interval counter: loaded when entering WAIT, counts down inside it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if ((r_state == S_W_CTRL) || (r_state == S_W_DC)) begin
            r_cnt <= r_interval;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - INT_W'(1);
        end
    end

    // Track the duty value most recently written to the port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dc_cur <= '0;
        end else if (r_state == S_W_DC0) begin
            r_dc_cur <= r_dc_start;
        end else if (r_state == S_W_DC) begin
            r_dc_cur <= w_next;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides every busy state except STOP/DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_state_nxt = S_W_DIV;
            S_W_DIV:  w_state_nxt = S_W_PER;
            S_W_PER:  w_state_nxt = S_W_DC0;
            S_W_DC0:  w_state_nxt = S_W_CTRL;
            S_W_CTRL: w_state_nxt = (r_dc_start == r_dc_end) ? S_DONE : S_WAIT;
            S_WAIT:   if (r_cnt == INT_W'(1)) w_state_nxt = S_W_DC;
            S_W_DC:   w_state_nxt = (w_next == r_dc_end) ? S_DONE : S_WAIT;
            S_DONE:   w_state_nxt = S_IDLE;
            S_STOP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (abort_i && (r_state != S_IDLE) && (r_state != S_DONE) &&
            (r_state != S_STOP))
            w_state_nxt = S_STOP;
    end

    // Moore register-port outputs decoded from the state.
    always_comb begin
        we_o    = 1'b0;
        addr_o  = 8'd0;
        wdata_o = 32'd0;
        case (r_state)
            S_W_DIV:  begin we_o = 1'b1; addr_o = w_base + 8'd4;  wdata_o = 32'(r_div);      end
            S_W_PER:  begin we_o = 1'b1; addr_o = w_base + 8'd8;  wdata_o = 32'(r_per);      end
            S_W_DC0:  begin we_o = 1'b1; addr_o = w_base + 8'd12; wdata_o = 32'(r_dc_start); end
            S_W_CTRL: begin we_o = 1'b1; addr_o = w_base;         wdata_o = c_ctrl_run;      end
            S_W_DC:   begin we_o = 1'b1; addr_o = w_base + 8'd12; wdata_o = 32'(w_next);     end
            S_STOP:   begin we_o = 1'b1; addr_o = w_base;         wdata_o = c_ctrl_stop;     end
            default:  ;
        endcase
    end

    assign re_o     = 1'b0;
    assign be_o     = we_o ? 4'hF : 4'h0;
    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign dc_cur_o = r_dc_cur;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_ctrl
// Purpose  : Self-checking bench for pwm_fade_ctrl: directed vector table,
//            abort/reset sequences and randomized ramps against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, abort_i, ch_sel_i;
    logic [15:0] cfg_divisor_i, cfg_period_i, dc_start_i, dc_end_i, dc_step_i;
    logic [23:0] interval_i;
    logic        we_o, re_o, busy_o, done_o;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic [15:0] dc_cur_o;

    pwm_fade_ctrl #(.DC_W(16), .INT_W(24)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .ch_sel_i(ch_sel_i), .cfg_divisor_i(cfg_divisor_i),
        .cfg_period_i(cfg_period_i), .dc_start_i(dc_start_i),
        .dc_end_i(dc_end_i), .dc_step_i(dc_step_i), .interval_i(interval_i),
        .we_o(we_o), .re_o(re_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .be_o(be_o), .busy_o(busy_o), .done_o(done_o), .dc_cur_o(dc_cur_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int     t;
        int     addr;
        longint data;
    } wr_t;

    typedef struct {
        bit ch;
        int div, per, s, e, step, intv;
        int n_dc, last_dc, done_t;
    } vec_t;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    bit  cap = 0;
    int  exp_done;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_q[$];
    vec_t vecs[6];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Capture every register write and done pulse, stamped relative to start.
    always @(negedge clk_i) begin
        if (cap) begin
            if (we_o) begin
                got_q.push_back('{cyc - t0, int'(addr_o), longint'(wdata_o)});
                chk("be_on_write", be_o, 4'hF);
                chk("re_zero", re_o, 0);
            end
            if (done_o) done_q.push_back(cyc - t0);
        end
    end

    // Reference model: expected write list from the ramp rules.
    task automatic build_exp(input bit ch, input int div, input int per,
                             input int s, input int e, input int step, input int intv);
        int base, n, cur, t;
        base = ch ? 16 : 0;
        n    = (intv == 0) ? 1 : intv;
        exp_q.delete();
        exp_q.push_back('{1, base + 4,  longint'(div)});
        exp_q.push_back('{2, base + 8,  longint'(per)});
        exp_q.push_back('{3, base + 12, longint'(s)});
        exp_q.push_back('{4, base,      64'h14});
        cur = s;
        t   = 4;
        while (cur != e) begin
            t += n + 1;
            if (step == 0)   cur = e;
            else if (e >= s) cur = (cur + step > e) ? e : cur + step;
            else             cur = (cur - step < e) ? e : cur - step;
            exp_q.push_back('{t, base + 12, longint'(cur)});
        end
        exp_done = t + 1;
    endtask

    task automatic kick(input bit ch, input int div, input int per,
                        input int s, input int e, input int step, input int intv);
        @(negedge clk_i);
        ch_sel_i      = ch;
        cfg_divisor_i = 16'(div);
        cfg_period_i  = 16'(per);
        dc_start_i    = 16'(s);
        dc_end_i      = 16'(e);
        dc_step_i     = 16'(step);
        interval_i    = 24'(intv);
        abort_i       = 1'b0;
        start_i       = 1'b1;
        got_q.delete();
        done_q.delete();
        t0  = cyc;
        cap = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        // Config changes after acceptance must have no effect.
        ch_sel_i      = ~ch;
        cfg_divisor_i = 16'($urandom);
        cfg_period_i  = 16'($urandom);
        dc_start_i    = 16'($urandom);
        dc_end_i      = 16'($urandom);
        dc_step_i     = 16'($urandom);
        interval_i    = 24'($urandom_range(0, 9));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o && k < 5000) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 5000) chk("idle_timeout", k, 0);
        cap = 1'b0;
    endtask

    task automatic run_seq(input bit ch, input int div, input int per,
                           input int s, input int e, input int step, input int intv);
        int m;
        build_exp(ch, div, per, s, e, step, intv);
        kick(ch, div, per, s, e, step, intv);
        wait_idle();
        chk("n_writes", got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk("wr_addr", got_q[i].addr, exp_q[i].addr);
            chk("wr_data", got_q[i].data, exp_q[i].data);
            chk("wr_cycle", got_q[i].t, exp_q[i].t);
        end
        chk("done_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("done_cycle", done_q[0], exp_done);
        chk("dc_cur_final", dc_cur_o, e);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 0; abort_i = 0; ch_sel_i = 0;
        cfg_divisor_i = 0; cfg_period_i = 0; dc_start_i = 0; dc_end_i = 0;
        dc_step_i = 0; interval_i = 0;

        //           ch div per    s       e       step  intv  nDC last   done
        vecs[0] = '{0, 2,  100,    0,      50,     20,   4,    3,  50,     20};
        vecs[1] = '{1, 3,  200,    10,     0,      4,    1,    3,  0,      11};
        vecs[2] = '{0, 5,  60,     7,      7,      9,    2,    0,  7,      5};
        vecs[3] = '{1, 1,  65535,  65520,  65535,  32,   2,    1,  65535,  8};
        vecs[4] = '{0, 4,  80,     100,    5,      0,    3,    1,  5,      9};
        vecs[5] = '{1, 7,  90,     0,      3,      1,    0,    3,  3,      11};

        // Reset state, with abort/start activity that must not matter.
        repeat (3) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        chk("rst_we", we_o, 0);
        chk("rst_re", re_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_be", be_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_dc_cur", dc_cur_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_abort_ignored", busy_o, 0);
        abort_i = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            run_seq(vecs[i].ch, vecs[i].div, vecs[i].per, vecs[i].s,
                    vecs[i].e, vecs[i].step, vecs[i].intv);
            chk("tbl_n_dc", got_q.size() - 4, vecs[i].n_dc);
            chk("tbl_last_dc", dc_cur_o, vecs[i].last_dc);
            if (done_q.size() > 0) chk("tbl_done_t", done_q[0], vecs[i].done_t);
        end

        // Abort during WAIT after DC=20; mid-ramp start must be ignored.
        kick(0, 2, 100, 0, 50, 20, 4);
        while (cyc - t0 < 7) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        while (cyc - t0 < 11) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("stop_we", we_o, 1);
        chk("stop_addr", addr_o, 0);
        chk("stop_data", wdata_o, 0);
        chk("stop_busy", busy_o, 1);
        @(negedge clk_i);
        chk("abort_busy_low", busy_o, 0);
        cap = 1'b0;
        chk("abort_n_writes", got_q.size(), 6);
        if (got_q.size() >= 6) begin
            chk("abort_dc_val", got_q[4].data, 20);
            chk("abort_dc_t", got_q[4].t, 9);
            chk("abort_stop_t", got_q[5].t, 12);
            chk("abort_ch_addr", got_q[0].addr, 4);
        end
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_dc_cur", dc_cur_o, 20);

        // Asynchronous reset mid-WAIT, then a full replay.
        kick(0, 2, 100, 0, 50, 20, 4);
        while (cyc - t0 < 11) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_we", we_o, 0);
        chk("arst_addr", addr_o, 0);
        chk("arst_wdata", wdata_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_dc_cur", dc_cur_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cap = 1'b0;
        run_seq(1, 9, 300, 40, 10, 15, 2);

        // Randomized ramps against the model.
        for (int r = 0; r < 24; r++) begin
            int s, e, st;
            if ($urandom_range(0, 3) == 0) begin
                s  = int'($urandom_range(0, 65535));
                e  = int'($urandom_range(0, 65535));
                st = int'($urandom_range(4096, 65535));
            end else begin
                s  = int'($urandom_range(0, 255));
                e  = int'($urandom_range(0, 255));
                st = int'($urandom_range(0, 40));
            end
            run_seq(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), s, e, st,
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Register-port sequencer for the dual-channel PWM peripheral. On a start request it programs one PWM channel's divisor, period, initial duty cycle and control word. It then steps the duty-cycle register from a start value to an end value at a fixed cycle interval, producing a hardware fade or ramp without CPU involvement. It sits between the system and the PWM register port and is the only writer of that port while busy.

## Interface
- DC_W, 16: duty/period/divisor/step width.
- INT_W, 24: interval counter width.

- clk_i  in  1  clock; also clocks the PWM register port.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin sequence. Sampled only in IDLE.
- abort_i  in  1  stop the running sequence. Sampled only when busy.
- ch_sel_i  in  1  channel select: 0 = ctrl/div/per/DC at 0/4/8/12; 1 = 16/20/24/28.
- cfg_divisor_i  in  DC_W  divisor value.
- cfg_period_i  in  DC_W  period value.
- dc_start_i, dc_end_i  in  DC_W  first and final duty cycle.
- dc_step_i  in  DC_W  duty-cycle increment per update.
- interval_i  in  INT_W  clk_i cycles between duty-cycle updates; 0 is treated as 1.
- we_o  out  1  register write strobe, one cycle per write.
- re_o  out  1  constant 0.
- addr_o  out  8  register byte address.
- wdata_o  out  32  write data; bits 31:16 always 0.
- be_o  out  4  4'hF whenever we_o=1, else 0.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the ramp reaches dc_end.
- dc_cur_o  out  DC_W  last duty cycle written.

## Operation
- All config inputs are latched on the cycle start_i is accepted. Later input changes have no effect until the next start.
- Direction: up if dc_end ≥ dc_start, else down.
- States: IDLE, W_DIV, W_PER, W_DC0, W_CTRL, WAIT, W_DC, DONE, STOP.
- Moore outputs. we_o=1 exactly in W_DIV, W_PER, W_DC0, W_CTRL, W_DC and STOP.
  - W_DIV: addr = base+4, data = divisor.
  - W_PER: addr = base+8, data = period.
  - W_DC0: addr = base+12, data = dc_start.
  - W_CTRL: addr = base, data = 0x14 (start, output enable, wb clock, internal DC).
  - W_DC: addr = base+12, data = next.
  - STOP: addr = base, data = 0x00.
- Transitions:
  - IDLE→W_DIV on start_i.
  - W_DIV→W_PER→W_DC0→W_CTRL.
  - W_CTRL→DONE if dc_start==dc_end, else →WAIT.
  - WAIT counts down max(interval,1) cycles, then →W_DC.
  - W_DC→DONE if next==dc_end, else →WAIT.
  - DONE→IDLE.
  - STOP→IDLE.
- next computation, done in DC_W+1 bits:
  - Up: next = min(cur+step, dc_end); overflow clamps to dc_end.
  - Down: next = max(cur−step, dc_end); underflow clamps to dc_end.
  - step=0: next = dc_end, so the ramp ends on the first update.
- dc_cur_o is updated to dc_start in W_DC0 and to next in W_DC, at the clock edge that leaves the state.
- Abort:
  - abort_i in any busy state other than STOP or DONE forces the next state to STOP.
  - A write presented in the abort cycle still completes.
  - done_o does not pulse on abort.
  - After an abort the PWM channel is stopped. After DONE it keeps running at dc_end.
- start_i while busy is ignored.
- abort_i in IDLE is ignored. If start_i and abort_i are both high in IDLE, start wins.

## Timing
- start_i accepted at edge 0:
  - W_DIV write in cycle 1, W_PER in 2, W_DC0 in 3, W_CTRL in 4.
  - First W_DC in cycle 5+max(interval,1).
  - Successive W_DC writes are max(interval,1)+1 cycles apart.
- DONE is the cycle after the final DC write. busy_o falls the cycle after DONE.
- Abort sampled at edge k puts the STOP write in cycle k+1; IDLE follows in k+2.
- Reset (asynchronous, active-high): state IDLE.
  - we_o=0, re_o=0, addr_o=0, wdata_o=0, be_o=0.
  - busy_o=0, done_o=0, dc_cur_o=0.
  - Interval counter and latched config are cleared.
  - Reset mid-sequence abandons it with no STOP write.

## Test plan
- Ramp up, ch0: div=2, per=100, start=0, end=50, step=20, interval=4 -> writes (4,2), (8,100), (12,0), (0,0x14), then (12,20), (12,40), (12,50) spaced 5 cycles apart. done_o pulses once; dc_cur_o=50.
- Ramp down, ch1: start=10, end=0, step=4, interval=1 -> addrs 20, 24, 28, 16; DC writes 6, 2, 0 spaced 2 cycles apart. The last value clamps.
- start=end=7 -> four setup writes only; done_o in cycle 5; no W_DC.
- Overflow: start=0xFFF0, end=0xFFFF, step=0x20 -> single W_DC write of 0xFFFF. step=0 case -> single write of dc_end.
- Abort during WAIT of test 1 after DC=20 -> next cycle write (0,0x00); busy_o low two cycles after abort; no done_o. start_i pulsed mid-ramp is ignored.
- rst_i asserted mid-WAIT (asynchronous, between edges) -> all outputs 0 immediately. After release, a new start replays the full four-write setup.
